timer_share_arbiter: RTL

Controller that shares one 4-bit down-count timer between NUM_REQ requesters. It picks one pending request by round-robin and issues the start command with that requester's preload value. It then waits for the timer rollover and returns a one-cycle done pulse to the owner. It sits between requester logic and the timer's command/flag ports and always runs the timer in one-shot mode.

---
 rtl/timer_share_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/timer_share_arbiter.sv
// rtl/timer_share_arbiter.sv - round-robin sharing of one one-shot down-count timer
module timer_share_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int WIDTH         = 4,
  // Must be at least 2: the error pulse is scheduled one cycle ahead of its slot
  parameter int START_TIMEOUT = 4
) (
  input  logic                       Clk_In,
  input  logic                       Reset_In,
  input  logic                       Enable_In,
  input  logic [NUM_REQ-1:0]         Req_Valid_In,
  input  logic [NUM_REQ*WIDTH-1:0]   Req_Preload_In,
  input  logic [NUM_REQ-1:0]         Req_Abort_In,
  output logic [NUM_REQ-1:0]         Grant_Out,
  output logic [NUM_REQ-1:0]         Done_Out,
  output logic                       Error_Out,
  output logic                       Busy_Out,
  output logic                       Start_Timer_Command_Out,
  output logic                       Stop_Timer_Command_Out,
  output logic                       Timer_Periodic_Oneshotb_Mode_Out,
  output logic [WIDTH-1:0]           Preload_Timer_Value_Out,
  input  logic                       Timer_Running_Flag_In,
  input  logic                       Timer_Rollover_Flag_In
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(START_TIMEOUT + 1);
  // Error_Out is registered, so it is scheduled in the cycle before the deadline
  localparam logic [CNT_W-1:0] ERR_AT = CNT_W'(START_TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_RUN,
    S_RUN,
    S_STOP,
    S_DONE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   wait_cnt;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [WIDTH-1:0]   pick_preload;
  logic               owner_abort;

  // The timer always runs one-shot
  assign Timer_Periodic_Oneshotb_Mode_Out = 1'b0;

  // Only the current owner's abort bit matters; other requesters cannot kill the job
  assign owner_abort = |(Req_Abort_In & Grant_Out);

  // Round-robin pick: scan downward in priority so the nearest requester after rr_ptr wins last
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    pick_idx = '0;
    pick_any = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      cand_idx = IDX_W'(cand);
      if (Req_Valid_In[cand_idx]) begin
        pick_idx = cand_idx;
        pick_any = 1'b1;
      end
    end
  end

  assign pick_onehot  = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
  assign pick_preload = Req_Preload_In[pick_idx*WIDTH +: WIDTH];

  // Job sequencer: grant, start pulse, wait for run/rollover, then done or stop
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state                   <= S_IDLE;
      rr_ptr                  <= IDX_W'(NUM_REQ - 1);
      wait_cnt                <= '0;
      Grant_Out               <= '0;
      Done_Out                <= '0;
      Error_Out               <= 1'b0;
      Busy_Out                <= 1'b0;
      Start_Timer_Command_Out <= 1'b0;
      Stop_Timer_Command_Out  <= 1'b0;
      Preload_Timer_Value_Out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Enable_In && pick_any) begin
            Grant_Out               <= pick_onehot;
            Preload_Timer_Value_Out <= pick_preload;
            rr_ptr                  <= pick_idx;
            Start_Timer_Command_Out <= 1'b1;
            Busy_Out                <= 1'b1;
            state                   <= S_START;
          end
        end

        S_START: begin
          Start_Timer_Command_Out <= 1'b0;
          wait_cnt                <= '0;
          state                   <= S_WAIT_RUN;
        end

        S_WAIT_RUN: begin
          if (Error_Out) begin
            // Timeout already declared; flags in this cycle are too late
            Error_Out              <= 1'b0;
            Stop_Timer_Command_Out <= 1'b1;
            state                  <= S_STOP;
          end else if (Timer_Rollover_Flag_In) begin
            // A zero preload may roll over without ever showing running
            Done_Out  <= Grant_Out;
            Grant_Out <= '0;
            state     <= S_DONE;
          end else if (Timer_Running_Flag_In) begin
            state <= S_RUN;
          end else begin
            if (wait_cnt == ERR_AT) begin
              Error_Out <= 1'b1;
            end
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_RUN: begin
          // Rollover beats a same-cycle abort: the job actually finished
          if (Timer_Rollover_Flag_In) begin
            Done_Out  <= Grant_Out;
            Grant_Out <= '0;
            state     <= S_DONE;
          end else if (owner_abort) begin
            Stop_Timer_Command_Out <= 1'b1;
            state                  <= S_STOP;
          end
        end

        S_STOP: begin
          Stop_Timer_Command_Out <= 1'b0;
          Grant_Out              <= '0;
          Busy_Out               <= 1'b0;
          state                  <= S_IDLE;
        end

        S_DONE: begin
          Done_Out <= '0;
          Busy_Out <= 1'b0;
          state    <= S_IDLE;
        end

        default: begin
          Grant_Out               <= '0;
          Done_Out                <= '0;
          Error_Out               <= 1'b0;
          Busy_Out                <= 1'b0;
          Start_Timer_Command_Out <= 1'b0;
          Stop_Timer_Command_Out  <= 1'b0;
          state                   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
